etapa_id_ex: RTL

- ID/EX pipeline register plus operand-select and forwarding stage.
- Latches decoded instruction fields from the decode stage on each clock.
- Resolves RAW hazards by forwarding from MEM and WB.
- Drives the ALU's valA, valB and 4-bit operacion directly.
- Supports stall (hold) and flush (bubble insertion) from the hazard/branch control.

---
 rtl/procesador_pkg.sv | 33 +++
 rtl/etapa_id_ex_if.sv | 63 ++++++
 rtl/etapa_id_ex_unidad_adelanto.sv | 40 ++++
 rtl/etapa_id_ex.sv | 108 ++++++++++
 4 files changed

// File: rtl/procesador_pkg.sv
// ============================================================================
// Module  : procesador_pkg
// Brief   : Shared ALU opcode encoding, operand-select codes and datapath
//           width defaults for the pipeline stages.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package procesador_pkg;

    localparam int ANCHO_DEF    = 32;
    localparam int REG_BITS_DEF = 5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_LUI  = 4'b1111;

    localparam logic SEL_A_RS1 = 1'b0;
    localparam logic SEL_A_PC  = 1'b1;
    localparam logic SEL_B_RS2 = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/etapa_id_ex_if.sv
// ============================================================================
// Module  : etapa_id_ex_if
// Brief   : Bundle between decode/hazard control, the later pipeline stages
//           and the ID/EX stage (slave = the stage itself).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface etapa_id_ex_if
    import procesador_pkg::*;
#(
    parameter int ANCHO    = ANCHO_DEF,
    parameter int REG_BITS = REG_BITS_DEF
);
    logic                stall;
    logic                flush;
    logic                id_valido;
    logic [ANCHO-1:0]    id_pc;
    logic [ANCHO-1:0]    id_rs1_val;
    logic [ANCHO-1:0]    id_rs2_val;
    logic [ANCHO-1:0]    id_imm;
    logic [REG_BITS-1:0] id_rs1;
    logic [REG_BITS-1:0] id_rs2;
    logic [REG_BITS-1:0] id_rd;
    logic                id_sel_a;
    logic                id_sel_b;
    logic [3:0]          id_operacion;
    logic                id_escribe_reg;
    logic [REG_BITS-1:0] mem_rd;
    logic                mem_escribe;
    logic [ANCHO-1:0]    mem_resultado;
    logic [REG_BITS-1:0] wb_rd;
    logic                wb_escribe;
    logic [ANCHO-1:0]    wb_dato;
    logic [ANCHO-1:0]    valA;
    logic [ANCHO-1:0]    valB;
    logic [3:0]          operacion;
    logic                ex_valido;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_escribe_reg;
    logic [ANCHO-1:0]    ex_pc;
    logic [ANCHO-1:0]    ex_dato_store;

    modport master (
        output stall, flush, id_valido, id_pc, id_rs1_val, id_rs2_val, id_imm,
               id_rs1, id_rs2, id_rd, id_sel_a, id_sel_b, id_operacion,
               id_escribe_reg, mem_rd, mem_escribe, mem_resultado,
               wb_rd, wb_escribe, wb_dato,
        input  valA, valB, operacion, ex_valido, ex_rd, ex_escribe_reg,
               ex_pc, ex_dato_store
    );

    modport slave (
        input  stall, flush, id_valido, id_pc, id_rs1_val, id_rs2_val, id_imm,
               id_rs1, id_rs2, id_rd, id_sel_a, id_sel_b, id_operacion,
               id_escribe_reg, mem_rd, mem_escribe, mem_resultado,
               wb_rd, wb_escribe, wb_dato,
        output valA, valB, operacion, ex_valido, ex_rd, ex_escribe_reg,
               ex_pc, ex_dato_store
    );
endinterface

`default_nettype wire

// File: rtl/etapa_id_ex_unidad_adelanto.sv
// ============================================================================
// Module  : unidad_adelanto
// Brief   : Single-operand forwarding: MEM beats WB beats the stored value;
//           register 0 never forwards.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module unidad_adelanto
    import procesador_pkg::*;
#(
    parameter int ANCHO    = ANCHO_DEF,
    parameter int REG_BITS = REG_BITS_DEF
) (
    input  wire logic [REG_BITS-1:0] rs,
    input  wire logic [ANCHO-1:0]    val_reg,
    input  wire logic [REG_BITS-1:0] mem_rd,
    input  wire logic                mem_escribe,
    input  wire logic [ANCHO-1:0]    mem_resultado,
    input  wire logic [REG_BITS-1:0] wb_rd,
    input  wire logic                wb_escribe,
    input  wire logic [ANCHO-1:0]    wb_dato,
    output      logic [ANCHO-1:0]    fwd
);
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_hit_mem = mem_escribe && (mem_rd != '0) && (mem_rd == rs);
    assign w_hit_wb  = wb_escribe  && (wb_rd  != '0) && (wb_rd  == rs);

    always_comb begin
        fwd = val_reg;
        if (w_hit_mem)
            fwd = mem_resultado;
        else if (w_hit_wb)
            fwd = wb_dato;
    end
endmodule

`default_nettype wire

// File: rtl/etapa_id_ex.sv
// ============================================================================
// Module  : etapa_id_ex
// Brief   : ID/EX pipeline register with stall/flush, write-through refresh
//           and MEM/WB operand forwarding feeding the ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module etapa_id_ex
    import procesador_pkg::*;
#(
    parameter int ANCHO    = ANCHO_DEF,
    parameter int REG_BITS = REG_BITS_DEF
) (
    input wire logic       clk,
    input wire logic       rst_n,
    etapa_id_ex_if.slave   bus
);
    logic                r_valido;
    logic [ANCHO-1:0]    r_pc;
    logic [ANCHO-1:0]    r_rs1_val;
    logic [ANCHO-1:0]    r_rs2_val;
    logic [ANCHO-1:0]    r_imm;
    logic [REG_BITS-1:0] r_rs1;
    logic [REG_BITS-1:0] r_rs2;
    logic [REG_BITS-1:0] r_rd;
    logic                r_sel_a;
    logic                r_sel_b;
    logic [3:0]          r_operacion;
    logic                r_escribe;

    logic [ANCHO-1:0]    w_fwd1;
    logic [ANCHO-1:0]    w_fwd2;
    logic                w_burbuja;

    assign w_burbuja = bus.flush || (!bus.stall && !bus.id_valido);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_burbuja) begin
            r_valido    <= 1'b0;
            r_pc        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_sel_a     <= SEL_A_RS1;
            r_sel_b     <= SEL_B_RS2;
            r_operacion <= OP_ADD;
            r_escribe   <= 1'b0;
        end else if (bus.stall) begin
            // The WB producer retires during the stall, so capture its value now
            if (bus.wb_escribe && (bus.wb_rd != '0) && (bus.wb_rd == r_rs1))
                r_rs1_val <= bus.wb_dato;
            if (bus.wb_escribe && (bus.wb_rd != '0) && (bus.wb_rd == r_rs2))
                r_rs2_val <= bus.wb_dato;
        end else begin
            r_valido    <= 1'b1;
            r_pc        <= bus.id_pc;
            r_rs1_val   <= bus.id_rs1_val;
            r_rs2_val   <= bus.id_rs2_val;
            r_imm       <= bus.id_imm;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_sel_a     <= bus.id_sel_a;
            r_sel_b     <= bus.id_sel_b;
            r_operacion <= bus.id_operacion;
            r_escribe   <= bus.id_escribe_reg;
        end
    end

    unidad_adelanto #(.ANCHO(ANCHO), .REG_BITS(REG_BITS)) u_adelanto_1 (
        .rs            (r_rs1),
        .val_reg       (r_rs1_val),
        .mem_rd        (bus.mem_rd),
        .mem_escribe   (bus.mem_escribe),
        .mem_resultado (bus.mem_resultado),
        .wb_rd         (bus.wb_rd),
        .wb_escribe    (bus.wb_escribe),
        .wb_dato       (bus.wb_dato),
        .fwd           (w_fwd1)
    );

    unidad_adelanto #(.ANCHO(ANCHO), .REG_BITS(REG_BITS)) u_adelanto_2 (
        .rs            (r_rs2),
        .val_reg       (r_rs2_val),
        .mem_rd        (bus.mem_rd),
        .mem_escribe   (bus.mem_escribe),
        .mem_resultado (bus.mem_resultado),
        .wb_rd         (bus.wb_rd),
        .wb_escribe    (bus.wb_escribe),
        .wb_dato       (bus.wb_dato),
        .fwd           (w_fwd2)
    );

    assign bus.valA           = (r_sel_a == SEL_A_PC)  ? r_pc  : w_fwd1;
    assign bus.valB           = (r_sel_b == SEL_B_IMM) ? r_imm : w_fwd2;
    assign bus.operacion      = r_operacion;
    assign bus.ex_valido      = r_valido;
    assign bus.ex_rd          = r_rd;
    assign bus.ex_escribe_reg = r_escribe;
    assign bus.ex_pc          = r_pc;
    assign bus.ex_dato_store  = w_fwd2;
endmodule

`default_nettype wire
